zigzag_scan_pp: RTL and testbench

ZIGZAG_SCAN_PP -- requirements
Module: zigzag_scan_pp

---
 rtl/zz_pkg.sv | 23 ++
 rtl/zz_walker.sv | 83 ++++++++
 rtl/zigzag_scan_pp.sv | 115 +++++++++++
 tb/tb_zigzag_scan_pp.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zz_pkg.sv
// Shared definitions for the ping-pong zigzag/transpose scan buffer.
package zz_pkg;

  typedef enum logic {
    ZZ_ZIGZAG    = 1'b0,
    ZZ_TRANSPOSE = 1'b1
  } zz_mode_e;

  function automatic bit zz_n_legal(input int unsigned n);
    return (n == 2) || (n == 4) || (n == 8) || (n == 16);
  endfunction

  // Row/column index width for an N-edge block.
  function automatic int unsigned zz_rc_w(input int unsigned n);
    return int'($clog2(n));
  endfunction

  // Raster address width for an N*N block.
  function automatic int unsigned zz_addr_w(input int unsigned n);
    return int'($clog2(n * n));
  endfunction

endpackage

// File: rtl/zz_walker.sv
// Row/column sequencer for zigzag or column-major scan of an N x N block.
module zz_walker
  import zz_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   step,
  input  logic                   clear,
  input  zz_mode_e               mode,
  output logic [zz_rc_w(N)-1:0]  row,
  output logic [zz_rc_w(N)-1:0]  col,
  output logic                   last
);

  localparam int unsigned RW = zz_rc_w(N);
  localparam logic [RW-1:0] EDGE = RW'(N - 1);

  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] col_q, col_d;
  logic          up_q, up_d;  // 1 = moving up-right, 0 = down-left

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
      up_q  <= 1'b1;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      up_q  <= up_d;
    end
  end

  // Next position: edges of the block bounce the diagonal walk.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    up_d  = up_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
      up_d  = 1'b1;
    end else if (step) begin
      if (mode == ZZ_TRANSPOSE) begin
        if (row_q == EDGE) begin
          row_d = '0;
          col_d = col_q + RW'(1);
        end else begin
          row_d = row_q + RW'(1);
        end
      end else if (up_q) begin
        if (col_q == EDGE) begin
          row_d = row_q + RW'(1);
          up_d  = 1'b0;
        end else if (row_q == '0) begin
          col_d = col_q + RW'(1);
          up_d  = 1'b0;
        end else begin
          row_d = row_q - RW'(1);
          col_d = col_q + RW'(1);
        end
      end else begin
        if (row_q == EDGE) begin
          col_d = col_q + RW'(1);
          up_d  = 1'b1;
        end else if (col_q == '0) begin
          row_d = row_q + RW'(1);
          up_d  = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
          col_d = col_q - RW'(1);
        end
      end
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == EDGE) && (col_q == EDGE);

endmodule

// File: rtl/zigzag_scan_pp.sv
// Ping-pong block buffer: raster-order writes, zigzag or transpose reads.
module zigzag_scan_pp
  import zz_pkg::*;
#(
  parameter int unsigned DW = 10,
  parameter int unsigned N  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_data,
  input  logic          in_mode,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_data,
  output logic          out_sof,
  output logic          out_eof
);

  localparam int unsigned RW    = zz_rc_w(N);
  localparam int unsigned AW    = zz_addr_w(N);
  localparam int unsigned DEPTH = N * N;

  if (!zz_n_legal(N)) begin : g_bad_n
    $error("zigzag_scan_pp: N must be 2, 4, 8 or 16");
  end

  logic [DW-1:0] mem_q [2][DEPTH];

  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic [1:0]    mode_q, mode_d;

  logic          in_xfer_c;
  logic          out_xfer_c;
  logic [RW-1:0] walk_row;
  logic [RW-1:0] walk_col;
  logic          walk_last;
  logic [AW-1:0] rd_addr_c;

  assign in_rdy     = ~full_q[wr_bank_q];
  assign out_vld    = full_q[rd_bank_q];
  assign in_xfer_c  = in_vld & in_rdy;
  assign out_xfer_c = out_vld & out_rdy;
  assign rd_addr_c  = {walk_row, walk_col};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      mode_q    <= '0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      mode_q    <= mode_d;
    end
  end

  // Sample storage is not reset; contents only matter once a bank is full.
  always_ff @(posedge clk) begin
    if (in_xfer_c) begin
      mem_q[wr_bank_q][wr_idx_q] <= in_data;
    end
  end

  // Writer fills one bank while the reader drains the other.
  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    mode_d    = mode_q;
    if (in_xfer_c) begin
      if (wr_idx_q == '0) begin
        mode_d[wr_bank_q] = in_mode;
      end
      if (wr_idx_q == AW'(DEPTH - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_idx_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + AW'(1);
      end
    end
    if (out_xfer_c && walk_last) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  zz_walker #(
    .N(N)
  ) u_walker (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (out_xfer_c),
    .clear (out_xfer_c & walk_last),
    .mode  (zz_mode_e'(mode_q[rd_bank_q])),
    .row   (walk_row),
    .col   (walk_col),
    .last  (walk_last)
  );

  assign out_data = mem_q[rd_bank_q][rd_addr_c];
  assign out_sof  = out_vld & (walk_row == '0) & (walk_col == '0);
  assign out_eof  = out_vld & walk_last;

endmodule

// File: tb/tb_zigzag_scan_pp.sv
// Directed bench for zigzag_scan_pp with N=8 and N=4 instances.
module tb_zigzag_scan_pp;

  localparam int unsigned DW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_vld, in_rdy, in_mode, out_vld, out_rdy, out_sof, out_eof;
  logic [DW-1:0] in_data, out_data;
  logic          in_vld4, in_rdy4, in_mode4, out_vld4, out_rdy4, out_sof4, out_eof4;
  logic [DW-1:0] in_data4, out_data4;

  zigzag_scan_pp #(.DW(DW), .N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_mode(in_mode),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof)
  );

  zigzag_scan_pp #(.DW(DW), .N(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld4), .in_rdy(in_rdy4), .in_data(in_data4), .in_mode(in_mode4),
    .out_vld(out_vld4), .out_rdy(out_rdy4), .out_data(out_data4),
    .out_sof(out_sof4), .out_eof(out_eof4)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          sof;
    logic          eof;
    int            cyc;
  } rec_t;

  typedef struct {
    bit n4;
    bit mode;
    int pos;
    int exp;
  } vec_t;

  rec_t q8[$];
  rec_t q4[$];
  vec_t tbl[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rdy_waits = 0;
  int last_in_cyc = 0;
  logic              hold_v = 1'b0;
  logic [DW+1:0]     hold_bits = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Capture output transfers and check that stalled outputs hold steady.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_v) begin
        chk("hold_vld", longint'(out_vld), 1);
        chk("hold_bits", longint'({out_data, out_sof, out_eof}), longint'(hold_bits));
      end
      hold_v    = out_vld && !out_rdy;
      hold_bits = {out_data, out_sof, out_eof};
      if (out_vld && out_rdy) q8.push_back('{out_data, out_sof, out_eof, cyc});
      if (out_vld4 && out_rdy4) q4.push_back('{out_data4, out_sof4, out_eof4, cyc});
    end else begin
      hold_v = 1'b0;
    end
  end

  // Zigzag reference: walk anti-diagonals, alternating direction.
  function automatic int zz_ref(input int n, input int p);
    int k = 0;
    for (int d = 0; d <= 2 * n - 2; d++) begin
      int lo = (d > n - 1) ? d - n + 1 : 0;
      int hi = (d < n - 1) ? d : n - 1;
      for (int i = 0; i <= hi - lo; i++) begin
        int r = (d % 2 == 1) ? lo + i : hi - i;
        if (k == p) return r * n + (d - r);
        k++;
      end
    end
    return -1;
  endfunction

  function automatic int tr_ref(input int n, input int p);
    return (p % n) * n + (p / n);
  endfunction

  task automatic push(input bit n4, input int d, input logic m);
    int g = 0;
    if (n4) begin
      in_vld4 = 1'b1; in_data4 = DW'(d); in_mode4 = m;
      while (!in_rdy4 && g < 1000) begin rdy_waits++; @(posedge clk); #1; g++; end
      chk("push4_rdy", longint'(in_rdy4), 1);
    end else begin
      in_vld = 1'b1; in_data = DW'(d); in_mode = m;
      while (!in_rdy && g < 1000) begin rdy_waits++; @(posedge clk); #1; g++; end
      chk("push8_rdy", longint'(in_rdy), 1);
    end
    last_in_cyc = cyc;
    @(posedge clk); #1;
    in_vld = 1'b0;
    in_vld4 = 1'b0;
  endtask

  task automatic send_block(input bit n4, input int base, input logic m, input bit toggle);
    int n = n4 ? 4 : 8;
    for (int i = 0; i < n * n; i++) begin
      push(n4, base + i, (toggle && (i % 2 == 1)) ? ~m : m);
    end
  endtask

  task automatic wait_out(input bit n4, input int count);
    int g = 0;
    while (((n4 ? q4.size() : q8.size()) < count) && g < 3000) begin
      @(negedge clk); g++;
    end
    chk(n4 ? "out_count4" : "out_count8", n4 ? q4.size() : q8.size(), count);
  endtask

  task automatic check_block(input bit n4, input int start, input int base,
                             input bit mode, input bit contiguous);
    int n = n4 ? 4 : 8;
    int sz = n4 ? q4.size() : q8.size();
    rec_t r, prev;
    if (sz < start + n * n) begin
      chk("blk_size", sz, start + n * n);
      return;
    end
    for (int p = 0; p < n * n; p++) begin
      r = n4 ? q4[start + p] : q8[start + p];
      chk("blk_data", longint'(r.d), base + (mode ? tr_ref(n, p) : zz_ref(n, p)));
      chk("blk_sof_eof", longint'({r.sof, r.eof}),
          longint'({p == 0, p == n * n - 1}));
      if (contiguous && p > 0) chk("blk_gap", r.cyc - prev.cyc, 1);
      prev = r;
    end
  endtask

  task automatic apply_table(input bit n4, input bit mode);
    rec_t r;
    foreach (tbl[i]) begin
      if (tbl[i].n4 == n4 && tbl[i].mode == mode) begin
        r = n4 ? q4[tbl[i].pos] : q8[tbl[i].pos];
        chk("tbl_vec", longint'(r.d), tbl[i].exp);
      end
    end
  endtask

  initial begin
    int zz8_head[10] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};
    int zz8_tail[4]  = '{47, 55, 62, 63};
    int zz4[16]      = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
    int t_in;

    foreach (zz8_head[i]) tbl.push_back('{1'b0, 1'b0, i, zz8_head[i]});
    foreach (zz8_tail[i]) tbl.push_back('{1'b0, 1'b0, 60 + i, zz8_tail[i]});
    tbl.push_back('{1'b0, 1'b1, 0, 0});
    tbl.push_back('{1'b0, 1'b1, 1, 8});
    tbl.push_back('{1'b0, 1'b1, 2, 16});
    tbl.push_back('{1'b0, 1'b1, 7, 56});
    tbl.push_back('{1'b0, 1'b1, 8, 1});
    tbl.push_back('{1'b0, 1'b1, 9, 9});
    tbl.push_back('{1'b0, 1'b1, 62, 55});
    tbl.push_back('{1'b0, 1'b1, 63, 63});
    foreach (zz4[i]) tbl.push_back('{1'b1, 1'b0, i, zz4[i]});

    in_vld = 0; in_data = '0; in_mode = 0; out_rdy = 1;
    in_vld4 = 0; in_data4 = '0; in_mode4 = 0; out_rdy4 = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", longint'(out_vld), 0);
    chk("rst_out_sof", longint'(out_sof), 0);
    chk("rst_out_eof", longint'(out_eof), 0);
    chk("rst_in_rdy", longint'(in_rdy), 1);
    chk("rst_in_rdy4", longint'(in_rdy4), 1);
    chk("rst_out_vld4", longint'(out_vld4), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // N=8 zigzag, with latency from last input to first output
    q8.delete();
    send_block(1'b0, 0, 1'b0, 1'b0);
    t_in = last_in_cyc;
    wait_out(1'b0, 64);
    if (q8.size() >= 64) begin
      chk("latency8", q8[0].cyc - t_in, 1);
      check_block(1'b0, 0, 0, 1'b0, 1'b1);
      apply_table(1'b0, 1'b0);
    end

    // N=8 transpose
    q8.delete();
    send_block(1'b0, 0, 1'b1, 1'b0);
    wait_out(1'b0, 64);
    if (q8.size() >= 64) begin
      check_block(1'b0, 0, 0, 1'b1, 1'b1);
      apply_table(1'b0, 1'b1);
    end

    // N=4 zigzag
    q4.delete();
    send_block(1'b1, 0, 1'b0, 1'b0);
    t_in = last_in_cyc;
    wait_out(1'b1, 16);
    if (q4.size() >= 16) begin
      chk("latency4", q4[0].cyc - t_in, 1);
      check_block(1'b1, 0, 0, 1'b0, 1'b1);
      apply_table(1'b1, 1'b0);
    end

    // Three back-to-back blocks: no input stalls, no output bubbles
    q8.delete();
    rdy_waits = 0;
    send_block(1'b0, 0, 1'b0, 1'b0);
    send_block(1'b0, 64, 1'b1, 1'b0);
    send_block(1'b0, 128, 1'b0, 1'b0);
    chk("b2b_rdy_waits", rdy_waits, 0);
    wait_out(1'b0, 192);
    if (q8.size() >= 192) begin
      check_block(1'b0, 0, 0, 1'b0, 1'b1);
      check_block(1'b0, 64, 64, 1'b1, 1'b1);
      check_block(1'b0, 128, 128, 1'b0, 1'b1);
      chk("b2b_span", q8[191].cyc - q8[0].cyc, 191);
    end

    // Output stall mid-block while two more blocks are offered
    q8.delete();
    rdy_waits = 0;
    fork
      begin
        send_block(1'b0, 300, 1'b1, 1'b0);
        send_block(1'b0, 364, 1'b0, 1'b0);
        send_block(1'b0, 428, 1'b1, 1'b0);
      end
      begin
        int g = 0;
        while (q8.size() < 10 && g < 1000) begin @(negedge clk); g++; end
        @(posedge clk); #1;
        out_rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_rdy = 1'b1;
      end
    join
    chk("stall_in_rdy_low", longint'(rdy_waits > 0), 1);
    wait_out(1'b0, 192);
    repeat (10) @(posedge clk);
    #1;
    chk("stall_no_dup", q8.size(), 192);
    if (q8.size() >= 192) begin
      check_block(1'b0, 0, 300, 1'b1, 1'b0);
      check_block(1'b0, 64, 364, 1'b0, 1'b1);
      check_block(1'b0, 128, 428, 1'b1, 1'b1);
    end

    // Partial block stays pending, then reset discards it
    q8.delete();
    for (int i = 0; i < 30; i++) push(1'b0, 900 + i, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("partial_pending", longint'(out_vld), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_vld", longint'(out_vld), 0);
    chk("midrst_in_rdy", longint'(in_rdy), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_block(1'b0, 500, 1'b1, 1'b1);
    wait_out(1'b0, 64);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_block_only", q8.size(), 64);
    if (q8.size() >= 64) check_block(1'b0, 0, 500, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
